// File: rtl/myfilter_pkg.sv
// myfilter shared definitions.
// Sizes, clock period and coefficient loader state type.
package myfilter_pkg;

  localparam int CMEMSIZE        = 4;
  localparam int DATABITS        = 8;
  localparam int CLK_PERIOD      = 10;
  localparam int CMEM_FRAME_BITS = CMEMSIZE * DATABITS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    DONE
  } cmem_loader_state_t;

endpackage

// File: rtl/cmem_loader.sv
// Serial write-side driver for cmem.
// Takes a frame of coefficient words and shifts each out MSB-first.
module cmem_loader #(
  parameter int CMEMSIZE = myfilter_pkg::CMEMSIZE,
  parameter int DATABITS = myfilter_pkg::DATABITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic                        word_valid_in,
  input  logic [DATABITS-1:0]         word_in,
  output logic                        word_ready_out,
  output logic                        sde_out,
  output logic                        sd_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [$clog2(CMEMSIZE)-1:0] word_idx_out
);

  import myfilter_pkg::*;

  localparam int IW = $clog2(CMEMSIZE);
  localparam int BW = $clog2(DATABITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CMEMSIZE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATABITS - 1);

  cmem_loader_state_t state_q, state_d;

  logic [DATABITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]       word_idx_q, word_idx_d;
  logic                sde_q, sd_q;
  logic                last_bit, last_word;

  assign last_bit  = (bit_cnt_q == '0);
  assign last_word = (word_idx_q == LAST_IDX);

  assign sde_out      = sde_q;
  assign sd_out       = sd_q;
  assign busy_out     = (state_q != IDLE);
  assign done_out     = (state_q == DONE);
  assign word_idx_out = word_idx_q;

  // Next state, handshake and shift/counter updates; abort overrides all.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    word_idx_d     = word_idx_q;
    word_ready_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = WAIT_WORD;
          word_idx_d = '0;
        end
      end
      WAIT_WORD: begin
        word_ready_out = 1'b1;
        if (word_valid_in) begin
          shreg_d   = word_in;
          bit_cnt_d = LAST_BIT;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else if (last_word) begin
          shreg_d = shreg_q << 1;
          state_d = DONE;
        end else begin
          word_ready_out = 1'b1;
          word_idx_d     = word_idx_q + IW'(1);
          if (word_valid_in) begin
            shreg_d   = word_in;
            bit_cnt_d = LAST_BIT;
          end else begin
            shreg_d = shreg_q << 1;
            state_d = WAIT_WORD;
          end
        end
      end
      DONE: begin
        word_idx_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_in) begin
      state_d        = IDLE;
      shreg_d        = '0;
      bit_cnt_d      = '0;
      word_idx_d     = '0;
      word_ready_out = 1'b0;
    end
  end

  // State, datapath and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      sde_q      <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      sde_q      <= (state_d == SHIFT);
      sd_q       <= (state_d == SHIFT) && shreg_d[DATABITS-1];
    end
  end

endmodule

// File: tb/tb_cmem_loader.sv
// Bench for cmem_loader with a behavioural cmem and stream model.
// Directed frames, stalls, abort, reset and protocol misuse.
module tb_cmem_loader;
  import myfilter_pkg::*;

  localparam int N  = CMEMSIZE;
  localparam int D  = DATABITS;
  localparam int IW = $clog2(CMEMSIZE);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic          abort_in;
  logic          word_valid_in;
  logic [D-1:0]  word_in;
  logic          word_ready_out;
  logic          sde_out;
  logic          sd_out;
  logic          busy_out;
  logic          done_out;
  logic [IW-1:0] word_idx_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmem_loader #(.CMEMSIZE(N), .DATABITS(D)) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .abort_in(abort_in),
    .word_valid_in(word_valid_in),
    .word_in(word_in),
    .word_ready_out(word_ready_out),
    .sde_out(sde_out),
    .sd_out(sd_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .word_idx_out(word_idx_out)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cmem: serial bits enter at addr 0 and push older words up.
  logic [N*D-1:0] chain = '0;
  always @(posedge clk) if (sde_out) chain <= {chain[N*D-2:0], sd_out};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Stream model: pending bits queue, frame word count, done/busy flags.
  logic q[$];
  bit   m_busy = 0;
  bit   m_done = 0;
  int   m_words = 0;
  int   t_start = 0;
  int   t_done = 0;
  int   n_done = 0;
  logic [D-1:0] rec = '0;
  int   rec_n = 0;

  // Compare DUT against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    int sz;
    bit popped;
    bit e_rdy;
    logic e_bit;
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_done = 0;
      m_words = 0;
      chk("rst_sde", int'(sde_out), 0);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_ready", int'(word_ready_out), 0);
    end else begin
      sz = q.size();
      popped = 0;
      e_rdy = m_busy && !m_done && (m_words < N) && (sz <= 1) && !abort_in;
      chk("sde", int'(sde_out), int'(sz > 0));
      if (sz > 0) begin
        e_bit = q.pop_front();
        popped = 1;
        chk("sd", int'(sd_out), int'(e_bit));
        rec = {rec[D-2:0], sd_out};
        rec_n++;
      end
      chk("busy", int'(busy_out), int'(m_busy));
      chk("done", int'(done_out), int'(m_done));
      chk("ready", int'(word_ready_out), int'(e_rdy));
      if (m_busy && !m_done)
        chk("idx", int'(word_idx_out), (sz > 0) ? m_words - 1 : m_words);
      if (done_out) begin
        t_done = cyc;
        n_done++;
      end
      if (abort_in) begin
        q.delete();
        m_busy = 0;
        m_done = 0;
        m_words = 0;
      end else if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else begin
        if (!m_busy && start_in) begin
          m_busy = 1;
          m_words = 0;
          t_start = cyc;
        end else if (e_rdy && word_valid_in) begin
          for (int i = D - 1; i >= 0; i--) q.push_back(word_in[i]);
          m_words++;
        end
        if (popped && q.size() == 0 && m_words == N) m_done = 1;
      end
    end
  end

  task automatic do_start();
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    abort_in = 1'b1;
    @(posedge clk); #1;
    abort_in = 1'b0;
  endtask

  // Present one word; hold valid low for 'gap' ready cycles first.
  task automatic send_word(input logic [D-1:0] w, input int gap);
    int n = 0;
    int g = gap;
    bit acc = 0;
    word_in = w;
    word_valid_in = (g == 0);
    while (!acc && n < 200) begin
      @(negedge clk);
      if (word_ready_out) begin
        if (word_valid_in) acc = 1;
        else if (g > 0) g--;
      end
      @(posedge clk); #1;
      n++;
      if (g == 0) word_valid_in = 1'b1;
    end
    word_valid_in = 1'b0;
    chk("accept_timeout", int'(acc), 1);
  endtask

  task automatic send_frame(input int gap_at);
    for (int k = 0; k < N; k++)
      send_word(D'(k + 1), (k == gap_at) ? 3 : 0);
  endtask

  task automatic wait_done();
    int n = 0;
    int prev = n_done;
    do begin
      @(negedge clk); #1;
      n++;
    end while (n_done == prev && n < 200);
    chk("done_timeout", int'(n_done != prev), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_cmem(input string nm);
    for (int a = 0; a < N; a++)
      chk(nm, int'(chain[a*D +: D]), N - a);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start_in = 1'b0;
    abort_in = 1'b0;
    word_valid_in = 1'b0;
    word_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_idx", int'(word_idx_out), 0);
    chk("reset_done", int'(done_out), 0);

    // Reset asserted mid-SHIFT drops outputs at once.
    @(posedge clk); #1;
    do_start();
    send_word(8'hFF, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_sde", int'(sde_out), 0);
    chk("arst_sd", int'(sd_out), 0);
    chk("arst_busy", int'(busy_out), 0);
    chk("arst_ready", int'(word_ready_out), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_busy", int'(busy_out), 0);

    // Single word A5, then waiting for word 1.
    @(posedge clk); #1;
    rec = '0;
    rec_n = 0;
    do_start();
    send_word(8'hA5, 0);
    repeat (9) @(negedge clk);
    #1;
    chk("a5_bits", int'(rec), 'hA5);
    chk("a5_nbits", rec_n, 8);
    chk("a5_idx", int'(word_idx_out), 1);
    chk("a5_ready", int'(word_ready_out), 1);
    do_abort();

    // Full back-to-back frame.
    @(posedge clk); #1;
    rec_n = 0;
    do_start();
    send_frame(-1);
    wait_done();
    chk("b2b_time", t_done - t_start, 34);
    chk("b2b_nbits", rec_n, 32);
    check_cmem("b2b_cmem");

    // Source stalls 3 cycles before word 2.
    chain = '0;
    @(posedge clk); #1;
    do_start();
    send_frame(2);
    wait_done();
    chk("stall_time", t_done - t_start, 37);
    check_cmem("stall_cmem");

    // Abort at bit 3 of word 2, then a clean reload.
    @(posedge clk); #1;
    nd = n_done;
    do_start();
    send_word(8'hF0, 0);
    send_word(8'h0F, 0);
    send_word(8'h3C, 0);
    repeat (2) @(posedge clk);
    #1;
    abort_in = 1'b1;
    @(posedge clk); #1;
    abort_in = 1'b0;
    @(negedge clk); #1;
    chk("abort_sde", int'(sde_out), 0);
    chk("abort_busy", int'(busy_out), 0);
    repeat (3) @(posedge clk);
    chk("abort_nodone", n_done - nd, 0);
    #1;
    do_start();
    send_frame(-1);
    wait_done();
    chk("reload_ndone", n_done - nd, 1);
    check_cmem("reload_cmem");

    // Valid in IDLE and start during SHIFT are both ignored.
    chain = '0;
    @(posedge clk); #1;
    word_in = 8'hEE;
    word_valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 word_valid_in = 1'b0;
    fork
      begin
        repeat (12) @(posedge clk);
        #1 start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
      end
    join_none
    do_start();
    send_frame(-1);
    wait_done();
    chk("misuse_time", t_done - t_start, 34);
    check_cmem("misuse_cmem");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
